// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_multiplier
// Purpose  : Sequential 8x8 unsigned multiplier. It accepts an operand pair on
//            a start pulse and performs one add-and-shift iteration per clock
//            through a single 8-bit ripple-carry adder with a 9-bit sum. The
//            16-bit product is returned together with a one-cycle done pulse.
// Ports    : clk     - rising-edge clock
//            rst     - synchronous, active-high reset
//            start   - request, sampled only while busy=0
//            a, b    - multiplicand / multiplier, captured on accept
//            busy    - high while iterations are in progress
//            done    - one-cycle pulse, product valid
//            product - result, held until the next completed multiply
// Options  : MULT_ZERO_SKIP_EN - when defined, a zero operand at accept time
//            goes straight to DONE with product 0 and never raises busy.
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // The adder datapath is fixed at 8 bits; any other width is rejected.
    generate
        if (WIDTH != 8) begin : g_width_check
            $error("shift_add_multiplier: WIDTH must be 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_last_iter = 4'd7;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [3:0]         r_cnt;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_carry;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic               w_accept;
    logic               w_zero_skip;

    // ------------------------------------------------------------------
    // Ripple-carry adder: ACC + M, full 9-bit result (carry kept).
    // ------------------------------------------------------------------
    assign w_carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_adder
            assign w_sum[gi]      = r_acc[gi] ^ r_m[gi] ^ w_carry[gi];
            assign w_carry[gi+1]  = (r_acc[gi] & r_m[gi]) |
                                    (w_carry[gi] & (r_acc[gi] ^ r_m[gi]));
        end
    endgenerate

    assign w_sum[WIDTH] = w_carry[WIDTH];

    // One iteration: add M when the current multiplier bit is set, then
    // shift {carry/0, ACC, Q} right by one; the carry lands in ACC[7].
    always_comb begin
        w_acc_nxt = r_acc >> 1;
        w_q_nxt   = {r_acc[0], r_q[WIDTH-1:1]};
        if (r_q[0]) begin
            w_acc_nxt = w_sum[WIDTH:1];
            w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
        end
    end

`ifdef MULT_ZERO_SKIP_EN
    assign w_zero_skip = (a == '0) || (b == '0);
`else
    assign w_zero_skip = 1'b0;
`endif

    // A start is honoured in IDLE and in DONE (back-to-back), never in RUN.
    assign w_accept = start && (r_state != ST_RUN);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_zero_skip ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (r_cnt == c_last_iter) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (w_accept) begin
                    w_state_nxt = w_zero_skip ? ST_DONE : ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m       <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_m   <= a;
            r_q   <= b;
            r_acc <= '0;
            r_cnt <= '0;
            if (w_zero_skip) begin
                r_product <= '0;
            end
        end else if (r_state == ST_RUN) begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt + 4'd1;
            // The product is taken from the post-shift values of the last
            // iteration, so it is complete in the same edge that enters DONE.
            if (r_cnt == c_last_iter) begin
                r_product <= {w_acc_nxt, w_q_nxt};
            end
        end
    end

    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_add_multiplier
// Purpose  : Directed self-checking bench for shift_add_multiplier. Expected
//            products are hand-computed constants; latency and busy length
//            follow the block's timing (done one edge after eight RUN cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_add_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int n_checks = 0;
    int n_pass   = 0;

    shift_add_multiplier #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MULT_ZERO_SKIP_EN
    localparam int c_zero_lat  = 0;
    localparam int c_zero_busy = 0;
`else
    localparam int c_zero_lat  = 8;
    localparam int c_zero_busy = 8;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at the falling edge just after the accept edge (offset 0).
    // Returns the number of edges after accept until done is seen and how
    // many sampled cycles had busy high. Bounded by a cycle budget.
    task automatic wait_done(output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    // Full single multiply: accept, wait, check latency/busy/product/pulse.
    task automatic run_mul(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                           input logic [15:0] exp, input int exp_lat, input int exp_busy);
        int lat;
        int nbusy;
        @(negedge clk);
        a     = ta;
        b     = tb;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        wait_done(lat, nbusy);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " busy_cycles"}, 32'(nbusy), 32'(exp_busy));
        chk({tag, " product"}, 32'(product), 32'(exp));
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, " product_held"}, 32'(product), 32'(exp));
    endtask

    initial begin
        int lat;
        int nbusy;
        int ndone;
        logic [15:0] seen;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        // Reset with random inputs toggling.
        repeat (2) begin
            @(negedge clk);
            start = 1'($urandom);
            a     = 8'($urandom);
            b     = 8'($urandom);
        end
        @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset product", 32'(product), 32'h0000);
        rst   = 1'b0;
        start = 1'b0;

        // Basic and carry-path vectors.
        run_mul("13x11",   8'd13,  8'd11,  16'h008F, 8, 8);
        run_mul("255x255", 8'd255, 8'd255, 16'hFE01, 8, 8);
        run_mul("128x2",   8'd128, 8'd2,   16'h0100, 8, 8);
        run_mul("200x3",   8'd200, 8'd3,   16'h0258, 8, 8);
        run_mul("1x255",   8'd1,   8'd255, 16'h00FF, 8, 8);

        // Busy collision: second request during RUN is ignored.
        @(negedge clk);
        a = 8'd3; b = 8'd5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 8'd200; b = 8'd200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        seen  = '0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                ndone++;
                seen = product;
            end
            @(negedge clk);
        end
        chk("collision done_count", 32'(ndone), 32'd1);
        chk("collision product", 32'(seen), 32'h000F);
        chk("collision idle_after", 32'(busy), 32'd0);

        // Back-to-back: start held across DONE.
        @(negedge clk);
        a = 8'd6; b = 8'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 8'd9; b = 8'd9;
        wait_done(lat, nbusy);
        chk("b2b first latency", 32'(lat), 32'd8);
        chk("b2b first product", 32'(product), 32'h002A);
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        chk("b2b second busy", 32'(busy), 32'd1);
        wait_done(lat, nbusy);
        chk("b2b second latency", 32'(lat), 32'd8);
        chk("b2b second product", 32'(product), 32'h0051);

        // Abort: rst during iteration 4 of 20x30.
        @(negedge clk);
        a = 8'd20; b = 8'd30; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort product", 32'(product), 32'h0000);
        chk("abort busy", 32'(busy), 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("abort no_done", 32'(ndone), 32'd0);

        // rst and start on the same edge: rst wins.
        @(negedge clk);
        a = 8'd5; b = 8'd5; start = 1'b1; rst = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        chk("rst_wins busy", 32'(busy), 32'd0);

        // Zero operands.
        run_mul("0x77",  8'd0,  8'd77, 16'h0000, c_zero_lat, c_zero_busy);
        run_mul("45x0",  8'd45, 8'd0,  16'h0000, c_zero_lat, c_zero_busy);
        run_mul("7x7",   8'd7,  8'd7,  16'h0031, 8, 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
